// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: state encoding and snapshot-frame layout shared by the register-dump engine.
package reg_dump_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DUMP = 2'd1,
      HOLD = 2'd2
   } dump_state_t;

   localparam int FRAME_WORDS = 34;
   localparam int WIDX_W      = 6;

   localparam logic [WIDX_W-1:0] W_PC    = 6'd0;
   localparam logic [WIDX_W-1:0] W_INSTR = 6'd1;
   localparam logic [WIDX_W-1:0] W_RF0   = 6'd2;
   localparam logic [WIDX_W-1:0] W_LAST  = 6'd33;

endpackage

// File: rtl/reg_dump_wdog.sv
// reg_dump_wdog: idle-cycle watchdog for the register-dump engine (REG_DUMP_TIMEOUT_EN builds only).
module reg_dump_wdog #(
   parameter int unsigned MAX_CYCLES = 1000
) (
   input  logic clk,
   input  logic rstn,
   input  logic count_en,
   input  logic clear,
   output logic expire
);

   logic [15:0] cnt_q;

   // Fires on the idle cycle whose increment would reach the limit, so entry
   // happens at the edge that ends the MAX_CYCLES-th idle clock.
   assign expire = count_en & (cnt_q == 16'(MAX_CYCLES - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (count_en) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: freezes the CPU on a breakpoint PC (or watchdog expiry when REG_DUMP_TIMEOUT_EN
// is defined) and streams a 34-word pc/instr/register snapshot over valid/ready.
//
// state | meaning
// IDLE  | watching pc for the break address (and the watchdog); CPU runs
// DUMP  | streaming frame words; CPU stalled
// HOLD  | frame sent; CPU stalled until a resume pulse
module reg_dump_unit
   import reg_dump_pkg::*;
#(
   parameter logic [31:0] BREAK_PC   = 32'h0000_0048,
   parameter int unsigned MAX_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   output logic [4:0]  reg_sel,
   input  logic [31:0] reg_data,
   output logic        cpu_stall,
   output logic        dump_valid,
   output logic [31:0] dump_data,
   output logic        dump_last,
   input  logic        dump_ready,
   output logic        dump_timeout,
   input  logic        resume
);

   dump_state_t       state_q, state_nxt;
   logic              armed_q;
   logic [WIDX_W-1:0] widx_q;
   logic [31:0]       instr_q;
   logic [31:0]       next_word;
   logic              bp_hit, wd_fire, enter, xfer;

   assign bp_hit = armed_q & (pc == BREAK_PC);
   assign xfer   = dump_valid & dump_ready;

`ifdef REG_DUMP_TIMEOUT_EN
   logic timeout_q;

   reg_dump_wdog #(
      .MAX_CYCLES(MAX_CYCLES)
   ) u_wdog (
      .clk     (clk),
      .rstn    (rstn),
      .count_en(state_q == IDLE),
      .clear   (enter),
      .expire  (wd_fire)
   );

   // A simultaneous breakpoint still reports the watchdog as the cause.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         timeout_q <= 1'b0;
      end else if (enter) begin
         timeout_q <= wd_fire;
      end
   end

   assign dump_timeout = timeout_q;
`else
   assign wd_fire      = 1'b0;
   assign dump_timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state_q;
      enter     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bp_hit | wd_fire) begin
               enter     = 1'b1;
               state_nxt = DUMP;
            end
         end
         DUMP: begin
            if (xfer && widx_q == W_LAST) state_nxt = HOLD;
         end
         HOLD: begin
            if (resume) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      next_word = reg_data;
      if (widx_q == W_PC) begin
         next_word = instr_q;
      end else if (widx_q == (W_RF0 - 6'd1)) begin
         next_word = 32'h0;
      end
   end

   // Gated by rstn so the stall releases the moment reset asserts, even with pc parked on the break address.
   assign cpu_stall = rstn & (enter | (state_q != IDLE));
   assign reg_sel   = (widx_q == W_PC) ? 5'd0 : 5'(widx_q - 6'd1);
   assign dump_last = dump_valid & (widx_q == W_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         armed_q    <= 1'b1;
         widx_q     <= W_PC;
         instr_q    <= '0;
         dump_data  <= '0;
         dump_valid <= 1'b0;
      end else begin
         if (enter) begin
            armed_q    <= 1'b0;
            widx_q     <= W_PC;
            instr_q    <= instr;
            dump_data  <= pc;
            dump_valid <= 1'b1;
         end else if (state_q == IDLE && pc != BREAK_PC) begin
            armed_q <= 1'b1;
         end
         if (state_q == DUMP && xfer) begin
            if (widx_q == W_LAST) begin
               dump_valid <= 1'b0;
            end else begin
               widx_q    <= widx_q + 6'd1;
               dump_data <= next_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: self-checking bench with a small CPU/register-file model and a frame scoreboard.
module tb_reg_dump_unit;

   localparam logic [31:0] BRK = 32'h0000_0048;
   localparam int unsigned MAXC = 20;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [4:0]  reg_sel;
   logic [31:0] reg_data;
   logic        cpu_stall;
   logic        dump_valid;
   logic [31:0] dump_data;
   logic        dump_last;
   logic        dump_ready = 1'b1;
   logic        dump_timeout;
   logic        resume = 1'b0;

   logic [31:0] rf [32];
   logic [31:0] pc_start = 32'h30;
   logic [31:0] loop_start = 32'h0;
   logic [31:0] loop_end = 32'hFFFF_FFFC;

   int n_cmp = 0;
   int n_bad = 0;
   int words_seen = 0;
   logic [31:0] w9_seen = '0;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [3:0]  pat;
      logic [31:0] r7;
      logic [31:0] exp_w9;
      int          exp_cycles;
   } vec_t;
   vec_t vecs[4];

   reg_dump_unit #(
      .BREAK_PC  (BRK),
      .MAX_CYCLES(MAXC)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .pc          (pc),
      .instr       (instr),
      .reg_sel     (reg_sel),
      .reg_data    (reg_data),
      .cpu_stall   (cpu_stall),
      .dump_valid  (dump_valid),
      .dump_data   (dump_data),
      .dump_last   (dump_last),
      .dump_ready  (dump_ready),
      .dump_timeout(dump_timeout),
      .resume      (resume)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {~a[15:0], 16'h0013};
   endfunction

   assign instr    = instr_of(pc);
   assign reg_data = rf[reg_sel];

   // CPU model: pc advances every unstalled edge, wrapping at loop_end.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) pc <= pc_start;
      else if (!cpu_stall) pc <= (pc == loop_end) ? loop_start : pc + 32'd4;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor plus backpressure stability check.
   logic        stall_prev = 1'b0;
   logic [37:0] held = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && dump_valid)
            chk("stall_stable", {26'd0, dump_last, reg_sel, dump_data}, {26'd0, held});
         stall_prev = dump_valid & ~dump_ready;
         held = {dump_last, reg_sel, dump_data};
         if (dump_valid && dump_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", {31'd0, dump_last, dump_data}, 64'h0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("word%0d", words_seen), {31'd0, dump_last, dump_data},
                   {31'd0, e.last, e.data});
            end
            if (words_seen == 9) w9_seen = dump_data;
            words_seen++;
         end
      end
   end

   task automatic init_rf(input logic [31:0] r7);
      rf[0] = 32'hFFFF_FFFF;
      for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + i * 32'h0101;
      rf[7] = r7;
   endtask

   task automatic push_frame(input logic [31:0] pcv);
      exp_q.push_back({pcv, 1'b0});
      exp_q.push_back({instr_of(pcv), 1'b0});
      exp_q.push_back({32'h0, 1'b0});
      for (int r = 1; r < 32; r++) exp_q.push_back({rf[r], r == 31});
   endtask

   task automatic do_reset(input logic [31:0] st, input logic [31:0] ls, input logic [31:0] le);
      pc_start = st;
      loop_start = ls;
      loop_end = le;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [3:0] pat, input int exp_cycles, input logic [31:0] pcv,
                            input int resume_at, input logic exp_to);
      bit saw = 0;
      bit moved = 0;
      bit resumed = 0;
      int nvalid = 0;
      words_seen = 0;
      if (dump_valid) saw = 1;
      for (int k = 0; k < 400; k++) begin
         dump_ready = pat[k % 4];
         resume = (resume_at >= 0) && !resumed && dump_valid && (words_seen >= resume_at);
         if (resume) resumed = 1;
         tick();
         resume = 1'b0;
         if (dump_valid) begin
            saw = 1;
            nvalid++;
            if (pc != pcv) moved = 1;
         end
         if (saw && !dump_valid) break;
      end
      dump_ready = 1'b1;
      chk("frame_seen", {63'd0, saw}, 64'd1);
      chk("frame_drained", exp_q.size(), 0);
      chk("pc_frozen", {63'd0, moved}, 64'd0);
      if (exp_cycles > 0) chk("frame_cycles", nvalid, exp_cycles);
      repeat (3) tick();
      chk("hold_stall", {63'd0, cpu_stall}, 64'd1);
      chk("hold_valid", {62'd0, dump_valid, dump_last}, 64'd0);
      chk("hold_pc", pc, pcv);
      chk("timeout_flag", {63'd0, dump_timeout}, {63'd0, exp_to});
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      vecs[0] = '{pat: 4'b1111, r7: 32'h0000_0005, exp_w9: 32'h0000_0005, exp_cycles: 34};
      vecs[1] = '{pat: 4'b1001, r7: 32'h0000_0005, exp_w9: 32'h0000_0005, exp_cycles: 0};
      vecs[2] = '{pat: 4'b1111, r7: 32'hCAFE_F00D, exp_w9: 32'hCAFE_F00D, exp_cycles: 34};
      vecs[3] = '{pat: 4'b0101, r7: 32'h1234_5678, exp_w9: 32'h1234_5678, exp_cycles: 0};

      init_rf(32'h5);
      rstn = 1'b0;
      #22;
      chk("rst_outputs", {28'd0, dump_valid, dump_last, dump_timeout, cpu_stall},  64'd0);
      chk("rst_data", {27'd0, reg_sel, dump_data}, 64'd0);

      foreach (vecs[i]) begin
         init_rf(vecs[i].r7);
         do_reset(32'h30, 32'h0, 32'hFFFF_FFFC);
         push_frame(BRK);
         run_frame(vecs[i].pat, vecs[i].exp_cycles, BRK, -1, 1'b0);
         chk($sformatf("vec%0d_w9", i), w9_seen, vecs[i].exp_w9);
      end

      // Resume from HOLD: no second frame at the same pc, re-arms once pc moves away.
      loop_start = 32'h40;
      loop_end = 32'h4C;
      @(negedge clk);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_stall", {63'd0, cpu_stall}, 64'd0);
      chk("resume_no_refire", {63'd0, dump_valid}, 64'd0);
      tick();
      chk("resume_pc_adv", pc, 32'h4C);
      chk("resume_no_refire2", {63'd0, dump_valid}, 64'd0);
      // The re-armed hit arrives via 0x40, 0x44; a resume pulse mid-frame must be ignored.
      push_frame(BRK);
      run_frame(4'b1111, 34, BRK, 10, 1'b0);
      repeat (4) tick();
      chk("dump_resume_ignored", {62'd0, cpu_stall, dump_valid}, 64'd2);

      // Reset at word 15 aborts the frame immediately; next hit gives a full frame.
      init_rf(32'h5);
      do_reset(32'h30, 32'h0, 32'hFFFF_FFFC);
      push_frame(BRK);
      words_seen = 0;
      dump_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (dump_valid && words_seen == 15) break;
      end
      chk("pre_abort_w15", dump_data, rf[13]);
      rstn = 1'b0;
      #1;
      chk("abort_outputs", {27'd0, dump_valid, dump_last, cpu_stall, reg_sel}, 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      push_frame(BRK);
      run_frame(4'b1111, 34, BRK, -1, 1'b0);

`ifdef REG_DUMP_TIMEOUT_EN
      // Loop over 0x0..0x10 never reaches BRK; the watchdog fires after MAXC idle clocks at pc 0x10.
      begin
         int n = 0;
         do_reset(32'h0, 32'h0, 32'h10);
         push_frame(32'h10);
         words_seen = 0;
         while (!dump_valid && n < 100) begin
            tick();
            n++;
         end
         chk("wdog_entry_cycles", n, MAXC);
         chk("wdog_timeout_flag", {63'd0, dump_timeout}, 64'd1);
         run_frame(4'b1111, 0, 32'h10, -1, 1'b1);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
